fp_div_seq: RTL and testbench
=============================

# fp_div_seq

Parametrised, multi-cycle IEEE-754 floating-point divider. It is the sequential successor to the single-cycle `div` path in the FP ALU. It computes a_in / b_in with a radix-2 restoring mantissa divider, one quotient bit per clock. It adds start/done handshaking, exponent overflow and underflow detection, special-operand handling and exception flags. It sits beside the add, sub and mul units behind the ALU operation select.

## Interface
- M, 8, exponent width
- N, 23, stored fraction width (word width M+N+1)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- a_in  in  M+N+1  dividend {sign, exp, frac}
- b_in  in  M+N+1  divisor
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, c_out and flags valid
- c_out  out  M+N+1  quotient, held until next accepted start
- flags  out  4  {invalid, div_by_zero, overflow, underflow}, held with c_out

## Operation
- States: IDLE, DIVIDE, NORM, DONE.
- IDLE + start:
  - Latch the operands.
  - sign = a_s ^ b_s.
  - Signed exponent, width M+2: e = ea − eb + (2^(M−1) − 1).
  - Mantissas: ma = {1, fa}, mb = {1, fb}.
  - Go to DIVIDE, or go straight to DONE if a special case applies.
- Subnormal inputs (exp = 0) are treated as zero. Subnormal outputs flush to zero.
- Special cases, in priority order:
  1. Any NaN, 0/0 or inf/inf: canonical qNaN {0, all-ones, 1, 0…}, invalid=1.
  2. finite≠0 / 0: signed inf, div_by_zero=1.
  3. inf / x: signed inf.
  4. 0 / x or x / inf: signed zero.
- DIVIDE, N+4 cycles, restoring:
  - rem starts at ma.
  - Each cycle: if rem ≥ mb, subtract mb and shift in quotient bit 1; otherwise shift in 0. Then rem <<= 1.
  - Result Q = floor(ma·2^(N+3)/mb), with N+4 bits. Since Q ∈ (2^(N+2), 2^(N+4)), bit N+3 or bit N+2 is set.
- NORM, 1 cycle:
  - If Q[N+3]=0, shift Q left by 1 and decrement e.
  - Significand = Q[N+3:3], guard = Q[2], sticky = |Q[1:0] | (rem≠0).
  - Apply rounding (see Configuration).
  - A rounding carry-out sets the significand to 1.0 and increments e.
  - e ≥ 2^M−1: signed inf, overflow=1.
  - e ≤ 0: signed zero, underflow=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- start while busy=1 is ignored and is not queued.
- start in the DONE cycle is ignored. The earliest new start is the cycle after done.

## Timing
- Reset values: busy=0, done=0, c_out=0, flags=0, state=IDLE.
- rst mid-operation aborts it. Next cycle is IDLE with all outputs zero and no done pulse.
- Start accepted at edge T. busy is high from T+1 until done.
- Normal latency: DIVIDE covers T+1..T+N+4, NORM is T+N+5, done is high in cycle T+N+6. That is 29 cycles for the default parameters.
- Special-case latency: done is high in cycle T+1.
- c_out and flags update in the same cycle done rises. They stay stable until the next accepted operation completes or rst.

## Configuration
- FP_DIV_ROUND_EN defined: round to nearest, ties to even, using guard, sticky and the significand LSB.
- FP_DIV_ROUND_EN undefined: truncate. Guard and sticky are ignored, the NORM rounding adder is removed, and latency is unchanged.

## Structure
- Package fp_pkg holds:
  - The state enum.
  - Bias and qNaN/inf/zero constants as functions of M and N.
  - The flag bit index constants.
- Sub-module fp_div_core holds the iterative mantissa divider: load, N+4 step counter, rem/Q registers and a core done. The top level owns unpack, special cases, normalise, round and pack.

## Test plan
- 0x40C00000 / 0x40000000 (6/2) -> c_out 0x40400000, flags 0, done at T+29.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB with FP_DIV_ROUND_EN, 0x3EAAAAAA without.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1, done at T+1. 0x80000000 / 0x80000000 -> 0x7FC00000, invalid=1.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1. 0x00800000 / 0x40000000 -> 0x00000000, underflow=1.
- start pulsed repeatedly during busy with different operands -> only the first operation completes, with a single done pulse.
- rst asserted at T+10 of an operation -> next cycle busy=0, c_out=0, no done. A following start completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential FP divider: state encoding, IEEE
// constant builders (functions of exponent width M and fraction width N)
// and exception flag bit positions.
package fp_pkg;

    // Divider FSM state encoding
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DIVIDE = 2'd1;
    localparam logic [1:0] ST_NORM   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Bit positions inside flags = {invalid, div_by_zero, overflow, underflow}
    localparam int FLAG_INVALID = 3;
    localparam int FLAG_DBZ     = 2;
    localparam int FLAG_OVF     = 1;
    localparam int FLAG_UNF     = 0;

    function automatic int fp_bias(input int m);
        return (1 << (m - 1)) - 1;
    endfunction

    // Positive infinity: exponent all ones, fraction zero
    function automatic logic [63:0] fp_inf(input int m, input int n);
        return ((64'd1 << m) - 64'd1) << n;
    endfunction

    // Canonical quiet NaN: positive, exponent all ones, fraction MSB set
    function automatic logic [63:0] fp_qnan(input int m, input int n);
        return (((64'd1 << m) - 64'd1) << n) | (64'd1 << (n - 1));
    endfunction

    function automatic logic [63:0] fp_zero(input int m, input int n);
        return 64'd0 & {32'(m), 32'(n)};
    endfunction

endpackage

// File: rtl/fp_div_core.sv
// Iterative radix-2 restoring mantissa divider. One quotient bit per clock,
// N+4 steps after load, Q = floor(ma * 2^(N+3) / mb).
module fp_div_core
    import fp_pkg::*;
#(
    parameter int N = 23
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [N:0]   ma,
    input  logic [N:0]   mb,
    output logic [N+3:0] q,
    output logic         rem_nz,
    output logic         core_done
);
    localparam int CW = $clog2(N + 5);

    logic [N+1:0] rem_q, rem_d;
    logic [N:0]   mb_q, mb_d;
    logic [N+3:0] q_q, q_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N+1:0] diff;

    // Load operands, then one compare/subtract/shift step per cycle until the counter expires
    always_comb begin
        rem_d = rem_q;
        mb_d  = mb_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        diff  = rem_q - {1'b0, mb_q};
        if (load) begin
            rem_d = {1'b0, ma};
            mb_d  = mb;
            q_d   = '0;
            cnt_d = CW'(N + 4);
        end else if (cnt_q != '0) begin
            if (rem_q >= {1'b0, mb_q}) begin
                rem_d = diff << 1;
                q_d   = {q_q[N+2:0], 1'b1};
            end else begin
                rem_d = rem_q << 1;
                q_d   = {q_q[N+2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Divider state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            mb_q  <= '0;
            q_q   <= '0;
            cnt_q <= '0;
        end else begin
            rem_q <= rem_d;
            mb_q  <= mb_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q         = q_q;
    assign rem_nz    = |rem_q;
    assign core_done = (cnt_q == CW'(1));

endmodule

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 divider: unpack, special operands, exponent, normalise,
// optional rounding and pack around the fp_div_core mantissa divider.
// Optional feature macro: FP_DIV_ROUND_EN (round to nearest even; default truncates).
//
// state     | meaning
// ST_IDLE   | waiting for start, operands sampled on start
// ST_DIVIDE | fp_div_core producing N+4 quotient bits
// ST_NORM   | normalise, round, range check, register result
// ST_DONE   | done pulse, result valid, back to idle
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int M = 8,
    parameter int N = 23
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [M+N:0]   a_in,
    input  logic [M+N:0]   b_in,
    output logic           busy,
    output logic           done,
    output logic [M+N:0]   c_out,
    output logic [3:0]     flags
);
    localparam int W = M + N + 1;
    localparam logic [W-1:0]        QNAN_W = W'(fp_qnan(M, N));
    localparam logic [W-1:0]        INF_W  = W'(fp_inf(M, N));
    localparam logic [W-1:0]        ZERO_W = W'(fp_zero(M, N));
    localparam logic signed [M+1:0] E_MAX  = (M+2)'((1 << M) - 1);
    localparam logic signed [M+1:0] E_ZERO = '0;

    logic [1:0]          state_q, state_d;
    logic                sign_q, sign_d;
    logic signed [M+1:0] exp_q, exp_d;
    logic [W-1:0]        c_out_q, c_out_d;
    logic [3:0]          flags_q, flags_d;

    logic [M-1:0] a_exp, b_exp;
    logic [N-1:0] a_frac, b_frac;
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_in;
    logic signed [M+1:0] e_calc;
    logic                is_special;
    logic [W-1:0]        spec_word;
    logic [3:0]          spec_flags;

    logic         core_load, core_done, rem_nz;
    logic [N+3:0] core_q;

    logic [N+3:0]        qn;
    logic signed [M+1:0] en;
    logic [N:0]          sig, sig_fin;
    logic [W-1:0]        norm_word;
    logic [3:0]          norm_flags;
    logic                norm_unused;

    assign a_exp   = a_in[W-2:N];
    assign b_exp   = b_in[W-2:N];
    assign a_frac  = a_in[N-1:0];
    assign b_frac  = b_in[N-1:0];
    assign a_zero  = (a_exp == '0);
    assign b_zero  = (b_exp == '0);
    assign a_nan   = (&a_exp) & (|a_frac);
    assign b_nan   = (&b_exp) & (|b_frac);
    assign a_inf   = (&a_exp) & ~(|a_frac);
    assign b_inf   = (&b_exp) & ~(|b_frac);
    assign sign_in = a_in[W-1] ^ b_in[W-1];
    assign e_calc  = {2'b00, a_exp} - {2'b00, b_exp} + (M+2)'(fp_bias(M));

    // Classify operand pairs that bypass the divider, in priority order
    always_comb begin
        is_special = 1'b1;
        spec_word  = ZERO_W;
        spec_flags = '0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_word                = QNAN_W;
            spec_flags[FLAG_INVALID] = 1'b1;
        end else if (b_zero && !a_inf) begin
            spec_word            = INF_W;
            spec_word[W-1]       = sign_in;
            spec_flags[FLAG_DBZ] = 1'b1;
        end else if (a_inf) begin
            spec_word      = INF_W;
            spec_word[W-1] = sign_in;
        end else if (a_zero || b_inf) begin
            spec_word[W-1] = sign_in;
        end else begin
            is_special = 1'b0;
        end
    end

    fp_div_core #(.N(N)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .ma        ({1'b1, a_frac}),
        .mb        ({1'b1, b_frac}),
        .q         (core_q),
        .rem_nz    (rem_nz),
        .core_done (core_done)
    );

    // Normalise the quotient, round, and range-check the exponent
    always_comb begin
        if (!core_q[N+3]) begin
            qn = core_q << 1;
            en = exp_q - (M+2)'(1);
        end else begin
            qn = core_q;
            en = exp_q;
        end
        sig = qn[N+3:3];
`ifdef FP_DIV_ROUND_EN
        begin
            logic [N+1:0] rnd;
            logic         inc;
            inc = qn[2] & ((|qn[1:0]) | rem_nz | sig[0]);
            rnd = {1'b0, sig} + {{(N+1){1'b0}}, inc};
            if (rnd[N+1]) begin
                sig_fin = {1'b1, {N{1'b0}}};
                en      = en + (M+2)'(1);
            end else begin
                sig_fin = rnd[N:0];
            end
        end
        norm_unused = sig_fin[N];
`else
        sig_fin     = sig;
        norm_unused = ^{qn[2:0], rem_nz, sig_fin[N]};
`endif
        norm_flags = '0;
        if (en >= E_MAX) begin
            norm_word            = INF_W;
            norm_word[W-1]       = sign_q;
            norm_flags[FLAG_OVF] = 1'b1;
        end else if (en <= E_ZERO) begin
            norm_word            = ZERO_W;
            norm_word[W-1]       = sign_q;
            norm_flags[FLAG_UNF] = 1'b1;
        end else begin
            norm_word = {sign_q, en[M-1:0], sig_fin[N-1:0]};
        end
    end

    // Next-state and result capture
    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        c_out_d   = c_out_q;
        flags_d   = flags_q;
        core_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d = sign_in;
                    exp_d  = e_calc;
                    if (is_special) begin
                        c_out_d = spec_word;
                        flags_d = spec_flags;
                        state_d = ST_DONE;
                    end else begin
                        core_load = 1'b1;
                        state_d   = ST_DIVIDE;
                    end
                end
            end
            ST_DIVIDE: if (core_done) state_d = ST_NORM;
            ST_NORM: begin
                c_out_d = norm_word;
                flags_d = norm_flags;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            c_out_q <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            c_out_q <= c_out_d;
            flags_q <= flags_d;
        end
    end

    assign busy  = (state_q == ST_DIVIDE) || (state_q == ST_NORM);
    assign done  = (state_q == ST_DONE);
    assign c_out = c_out_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq (default M=8, N=23).
module tb_fp_div_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a_in = '0;
    logic [31:0] b_in = '0;
    logic        busy, done;
    logic [31:0] c_out;
    logic [3:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    fp_div_seq #(.M(8), .N(23)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a_in  (a_in),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .c_out (c_out),
        .flags (flags)
    );

    always #5 clk = ~clk;

    // Issue one operation; lat is the cycle (relative to accept edge T) in which done is seen, -1 on timeout
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output logic [3:0] f,
                         output int lat, output logic busy1);
        @(negedge clk);
        a_in = a; b_in = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = busy;
        lat = -1; c = '0; f = '0;
        for (int i = 1; i <= 100; i++) begin
            if (done) begin
                lat = i; c = c_out; f = flags;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (c_out !== 32'h0) $display("FAIL reset_c_out: got %h want 00000000", c_out); else n_pass++;
        n_checks++; if (flags !== 4'h0) $display("FAIL reset_flags: got %b want 0000", flags); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] c, exp_third; logic [3:0] f; int lat; logic b1;
        do_op(32'h40C00000, 32'h40000000, c, f, lat, b1);
        n_checks++; if (c !== 32'h40400000) $display("FAIL six_div_two_c: got %h want 40400000", c); else n_pass++;
        n_checks++; if (f !== 4'h0) $display("FAIL six_div_two_flags: got %b want 0000", f); else n_pass++;
        n_checks++; if (lat !== 29) $display("FAIL six_div_two_latency: got %0d want 29", lat); else n_pass++;
        n_checks++; if (b1 !== 1'b1) $display("FAIL busy_after_start: got %b want 1", b1); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (c_out !== 32'h40400000) $display("FAIL c_out_held: got %h want 40400000", c_out); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL done_single_pulse: got %b want 0", done); else n_pass++;
`ifdef FP_DIV_ROUND_EN
        exp_third = 32'h3EAAAAAB;
`else
        exp_third = 32'h3EAAAAAA;
`endif
        do_op(32'h3F800000, 32'h40400000, c, f, lat, b1);
        n_checks++; if (c !== exp_third) $display("FAIL one_third_c: got %h want %h", c, exp_third); else n_pass++;
        n_checks++; if (f !== 4'h0) $display("FAIL one_third_flags: got %b want 0000", f); else n_pass++;
        // -9 / 0.75 = -12, exact
        do_op(32'hC1100000, 32'h3F400000, c, f, lat, b1);
        n_checks++; if (c !== 32'hC1400000) $display("FAIL neg_nine_c: got %h want c1400000", c); else n_pass++;
    endtask

    task automatic test_special();
        logic [31:0] c; logic [3:0] f; int lat; logic b1;
        do_op(32'h3F800000, 32'h00000000, c, f, lat, b1);
        n_checks++; if (c !== 32'h7F800000) $display("FAIL div_zero_c: got %h want 7f800000", c); else n_pass++;
        n_checks++; if (f !== 4'b0100) $display("FAIL div_zero_flags: got %b want 0100", f); else n_pass++;
        n_checks++; if (lat !== 1) $display("FAIL div_zero_latency: got %0d want 1", lat); else n_pass++;
        do_op(32'h80000000, 32'h80000000, c, f, lat, b1);
        n_checks++; if (c !== 32'h7FC00000) $display("FAIL zero_zero_c: got %h want 7fc00000", c); else n_pass++;
        n_checks++; if (f !== 4'b1000) $display("FAIL zero_zero_flags: got %b want 1000", f); else n_pass++;
        do_op(32'hFF800000, 32'h40000000, c, f, lat, b1);
        n_checks++; if (c !== 32'hFF800000 || f !== 4'b0000) $display("FAIL inf_div_x: got %h/%b want ff800000/0000", c, f); else n_pass++;
        do_op(32'h40000000, 32'hFF800000, c, f, lat, b1);
        n_checks++; if (c !== 32'h80000000 || f !== 4'b0000) $display("FAIL x_div_inf: got %h/%b want 80000000/0000", c, f); else n_pass++;
        do_op(32'h7F800001, 32'h3F800000, c, f, lat, b1);
        n_checks++; if (c !== 32'h7FC00000 || f !== 4'b1000) $display("FAIL nan_in: got %h/%b want 7fc00000/1000", c, f); else n_pass++;
    endtask

    task automatic test_range();
        logic [31:0] c; logic [3:0] f; int lat; logic b1;
        do_op(32'h7F000000, 32'h3E800000, c, f, lat, b1);
        n_checks++; if (c !== 32'h7F800000) $display("FAIL overflow_c: got %h want 7f800000", c); else n_pass++;
        n_checks++; if (f !== 4'b0010) $display("FAIL overflow_flags: got %b want 0010", f); else n_pass++;
        n_checks++; if (lat !== 29) $display("FAIL overflow_latency: got %0d want 29", lat); else n_pass++;
        do_op(32'h00800000, 32'h40000000, c, f, lat, b1);
        n_checks++; if (c !== 32'h00000000) $display("FAIL underflow_c: got %h want 00000000", c); else n_pass++;
        n_checks++; if (f !== 4'b0001) $display("FAIL underflow_flags: got %b want 0001", f); else n_pass++;
    endtask

    task automatic test_busy_ignore();
        int dones = 0; int lat = -1;
        @(negedge clk);
        a_in = 32'h40C00000; b_in = 32'h40000000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            if (done) begin
                dones++;
                if (lat < 0) lat = i;
            end
            a_in = 32'h3F800000; b_in = 32'h40400000;
            start = (busy || done) && (i % 2 == 1);
            @(negedge clk);
        end
        start = 1'b0;
        n_checks++; if (dones !== 1) $display("FAIL busy_ignore_dones: got %0d want 1", dones); else n_pass++;
        n_checks++; if (lat !== 29) $display("FAIL busy_ignore_latency: got %0d want 29", lat); else n_pass++;
        n_checks++; if (c_out !== 32'h40400000) $display("FAIL busy_ignore_c: got %h want 40400000", c_out); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] c; logic [3:0] f; int lat; logic b1; int dones = 0;
        @(negedge clk);
        a_in = 32'h3F800000; b_in = 32'h40400000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (c_out !== 32'h0) $display("FAIL mid_rst_c_out: got %h want 00000000", c_out); else n_pass++;
        n_checks++; if (flags !== 4'h0) $display("FAIL mid_rst_flags: got %b want 0000", flags); else n_pass++;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        n_checks++; if (dones !== 0) $display("FAIL mid_rst_no_done: got %0d want 0", dones); else n_pass++;
        do_op(32'h40C00000, 32'h40000000, c, f, lat, b1);
        n_checks++; if (c !== 32'h40400000 || lat !== 29) $display("FAIL after_rst_op: got %h lat %0d want 40400000 lat 29", c, lat); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_busy_ignore();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
